// File: rtl/systolic_pkg.sv
// Shared systolic-array constants and drain FSM state type.
package systolic_pkg;

  localparam int unsigned systolic_size_c = 4;
  localparam int unsigned acc_w_c         = 32;
  localparam int unsigned out_w_c         = 16;

  typedef enum logic [0:0] {
    IDLE,
    STREAM
  } drain_state_e;

endpackage

// File: rtl/drain_sat.sv
// Reduces one signed ACC_W accumulator to OUT_W bits.
// DRAIN_SATURATE_EN selects clamping; otherwise the low bits are kept (wraps).
module drain_sat #(
  parameter int unsigned ACC_W = 32,
  parameter int unsigned OUT_W = 16
) (
  input  logic [ACC_W-1:0] acc_i,
  output logic [OUT_W-1:0] out_o
);

`ifdef DRAIN_SATURATE_EN
  // Value fits iff every bit from the OUT_W sign position upward matches.
  logic [ACC_W-OUT_W:0] w_hi;
  logic                 w_fits;

  assign w_hi   = acc_i[ACC_W-1:OUT_W-1];
  assign w_fits = (&w_hi) | (~|w_hi);

  always_comb begin
    out_o = acc_i[OUT_W-1:0];
    if (!w_fits) begin
      out_o = acc_i[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
`else
  assign out_o = acc_i[OUT_W-1:0];

  if (OUT_W < ACC_W) begin : g_hi
    logic w_unused_hi;
    assign w_unused_hi = ^acc_i[ACC_W-1:OUT_W];
  end
`endif

endmodule

// File: rtl/mac_array_drain.sv
// Captures a full SIZE x SIZE accumulator matrix and streams it out one row per beat.
// Element reduction is controlled by DRAIN_SATURATE_EN (see drain_sat).
module mac_array_drain
  import systolic_pkg::*;
#(
  parameter int unsigned SIZE  = systolic_size_c,
  parameter int unsigned ACC_W = acc_w_c,
  parameter int unsigned OUT_W = out_w_c
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          acc_valid_i,
  input  logic [SIZE*SIZE*ACC_W-1:0]    acc_data_i,
  output logic                          acc_ready_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [SIZE*OUT_W-1:0]         out_data_o,
  output logic [$clog2(SIZE)-1:0]       out_row_o,
  output logic                          out_last_o,
  output logic                          drop_o
);

  localparam int unsigned     RowW    = $clog2(SIZE);
  localparam logic [RowW-1:0] LastRow = RowW'(SIZE - 1);

  drain_state_e               r_state;
  logic [RowW-1:0]            r_row;
  logic [SIZE*SIZE*ACC_W-1:0] r_mat;
  logic                       r_drop;

  logic                  w_hs;
  logic                  w_capture;
  logic [SIZE*ACC_W-1:0] w_row_data;

  assign out_valid_o = (r_state == STREAM);
  assign out_last_o  = out_valid_o & (r_row == LastRow);
  assign out_row_o   = r_row;
  assign drop_o      = r_drop;

  assign w_hs        = out_valid_o & out_ready_i;
  // Ready during the final handshake lets a new matrix follow with no bubble.
  assign acc_ready_o = (r_state == IDLE) | (w_hs & out_last_o);
  assign w_capture   = acc_valid_i & acc_ready_o;

  assign w_row_data  = r_mat[r_row * (SIZE * ACC_W) +: SIZE * ACC_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_row   <= '0;
      r_mat   <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_drop <= acc_valid_i & ~acc_ready_o;
      if (w_capture) begin
        r_mat   <= acc_data_i;
        r_state <= STREAM;
        r_row   <= '0;
      end else if (w_hs) begin
        if (out_last_o) begin
          r_state <= IDLE;
          r_row   <= '0;
        end else begin
          r_row <= r_row + 1'b1;
        end
      end
    end
  end

  for (genvar c = 0; c < SIZE; c++) begin : g_sat
    drain_sat #(
      .ACC_W(ACC_W),
      .OUT_W(OUT_W)
    ) u_sat (
      .acc_i(w_row_data[c*ACC_W +: ACC_W]),
      .out_o(out_data_o[c*OUT_W +: OUT_W])
    );
  end

endmodule

// File: tb/tb_mac_array_drain.sv
// Directed bench for mac_array_drain: drain, backpressure, back-to-back, drop,
// reduction and mid-stream reset.
module tb_mac_array_drain;
  import systolic_pkg::*;

  localparam int unsigned SIZE  = 4;
  localparam int unsigned ACC_W = 32;
  localparam int unsigned OUT_W = 16;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       acc_valid_i;
  logic [SIZE*SIZE*ACC_W-1:0] acc_data_i;
  logic                       acc_ready_o;
  logic                       out_valid_o;
  logic                       out_ready_i;
  logic [SIZE*OUT_W-1:0]      out_data_o;
  logic [1:0]                 out_row_o;
  logic                       out_last_o;
  logic                       drop_o;

  int n_checks = 0;
  int n_errors = 0;
  int hs_cnt   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (out_valid_o && out_ready_i) hs_cnt++;

  mac_array_drain #(
    .SIZE (SIZE),
    .ACC_W(ACC_W),
    .OUT_W(OUT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .acc_valid_i(acc_valid_i),
    .acc_data_i (acc_data_i),
    .acc_ready_o(acc_ready_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (out_data_o),
    .out_row_o  (out_row_o),
    .out_last_o (out_last_o),
    .drop_o     (drop_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // PE(r,c) = base + 10r + c
  function automatic logic [SIZE*SIZE*ACC_W-1:0] mat(input int base);
    logic [SIZE*SIZE*ACC_W-1:0] m;
    m = '0;
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++)
        m[(r*SIZE+c)*ACC_W +: ACC_W] = base + 10*r + c;
    return m;
  endfunction

  function automatic logic [63:0] row_of(input int base, input int r);
    logic [63:0] res;
    int v;
    res = '0;
    for (int c = 0; c < SIZE; c++) begin
      v = base + 10*r + c;
      res[c*OUT_W +: OUT_W] = v[15:0];
    end
    return res;
  endfunction

  task automatic beat(input string tag, input int base, input int r);
    check({tag, "_valid"}, 64'(out_valid_o), 64'd1);
    check({tag, "_row"},   64'(out_row_o),   64'(r));
    check({tag, "_data"},  64'(out_data_o),  row_of(base, r));
    check({tag, "_last"},  64'(out_last_o),  64'(r == SIZE - 1));
  endtask

  task automatic load(input int base);
    acc_valid_i = 1'b1;
    acc_data_i  = mat(base);
    tick();
    acc_valid_i = 1'b0;
  endtask

  initial begin
    logic [SIZE*SIZE*ACC_W-1:0] m;
    int v;
    int hs0;

    rst = 1'b1; acc_valid_i = 1'b0; acc_data_i = '0; out_ready_i = 1'b1;
    #1;
    check("rst_valid", 64'(out_valid_o), 64'd0);
    check("rst_drop",  64'(drop_o),      64'd0);
    check("rst_data",  64'(out_data_o),  64'd0);
    check("rst_row",   64'(out_row_o),   64'd0);
    check("rst_last",  64'(out_last_o),  64'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rel_ready", 64'(acc_ready_o), 64'd1);

    // Basic drain
    load(0);
    for (int r = 0; r < SIZE; r++) begin
      beat("basic", 0, r);
      if (r == 2) check("basic_row2", 64'(out_data_o), 64'h0017_0016_0015_0014);
      tick();
    end
    check("basic_idle", 64'(out_valid_o), 64'd0);

    // Backpressure on row 1
    hs0 = hs_cnt;
    load(100);
    beat("bp", 100, 0);
    tick();
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat("bp_hold", 100, 1);
      check("bp_not_ready", 64'(acc_ready_o), 64'd0);
      tick();
    end
    out_ready_i = 1'b1;
    for (int r = 1; r < SIZE; r++) begin
      beat("bp", 100, r);
      tick();
    end
    check("bp_idle", 64'(out_valid_o), 64'd0);
    check("bp_hs",   64'(hs_cnt - hs0), 64'd4);

    // Back-to-back capture on last handshake
    load(200);
    for (int r = 0; r < SIZE - 1; r++) begin
      beat("b2b_a", 200, r);
      tick();
    end
    beat("b2b_a", 200, 3);
    acc_valid_i = 1'b1;
    acc_data_i  = mat(300);
    check("b2b_ready", 64'(acc_ready_o), 64'd1);
    tick();
    acc_valid_i = 1'b0;
    for (int r = 0; r < SIZE; r++) begin
      beat("b2b_b", 300, r);
      tick();
    end
    check("b2b_idle", 64'(out_valid_o), 64'd0);

    // Drop while streaming
    load(400);
    beat("drop", 400, 0);
    tick();
    beat("drop", 400, 1);
    acc_valid_i = 1'b1;
    acc_data_i  = mat(500);
    check("drop_ready", 64'(acc_ready_o), 64'd0);
    check("drop_pre",   64'(drop_o),      64'd0);
    tick();
    acc_valid_i = 1'b0;
    check("drop_pulse", 64'(drop_o), 64'd1);
    beat("drop", 400, 2);
    tick();
    check("drop_clear", 64'(drop_o), 64'd0);
    beat("drop", 400, 3);
    tick();
    check("drop_idle", 64'(out_valid_o), 64'd0);

    // Element reduction on row 0
    m = '0;
    m[31:0]  = 32'h0001_2345;
    v = -70000;
    m[63:32] = v;
    v = -5;
    m[95:64] = v;
    m[127:96] = 32'h0000_7FFF;
    acc_valid_i = 1'b1;
    acc_data_i  = m;
    tick();
    acc_valid_i = 1'b0;
`ifdef DRAIN_SATURATE_EN
    check("red_sat",   64'(out_data_o), 64'h7FFF_FFFB_8000_7FFF);
`else
    check("red_trunc", 64'(out_data_o), 64'h7FFF_FFFB_EE90_2345);
`endif
    for (int i = 0; i < SIZE; i++) tick();
    check("red_idle", 64'(out_valid_o), 64'd0);

    // Reset in the middle of a stream
    load(600);
    tick();
    tick();
    beat("rstm", 600, 2);
    rst = 1'b1;
    #1;
    check("rstm_valid", 64'(out_valid_o), 64'd0);
    check("rstm_row",   64'(out_row_o),   64'd0);
    check("rstm_data",  64'(out_data_o),  64'd0);
    tick();
    rst = 1'b0;
    tick();
    check("rstm_ready", 64'(acc_ready_o), 64'd1);
    check("rstm_idle",  64'(out_valid_o), 64'd0);
    load(700);
    for (int r = 0; r < SIZE; r++) begin
      beat("rstm_new", 700, r);
      tick();
    end
    check("rstm_end", 64'(out_valid_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
